branch_resolve_unit: RTL and testbench

//  Execute-stage counterpart of the fetch-side branch predictor. Compares each resolved branch/jump

---
 rtl/bru_pkg.sv | 33 +++
 rtl/bru_sat_counter.sv | 31 +++
 rtl/branch_resolve_unit.sv | 147 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// ---------------------------------------------------------------------------
// bru_pkg
// Shared types and constants for the branch resolve unit.
//   bru_state_e  : resolve FSM state (IDLE / FLUSH)
//   bp_update_t  : predictor update record (update strobe, taken, way, pc,
//                  target); address fields sized to BRU_ADDR_W, the widest
//                  address the unit supports
//   flush_cnt_w(): width of the flush down-counter for a given flush length
// ---------------------------------------------------------------------------
package bru_pkg;

  localparam int BRU_ADDR_W         = 64;
  localparam int FLUSH_CYCLES_DEF   = 2;
  localparam int FLUSH_CNT_W        = $clog2(FLUSH_CYCLES_DEF + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic                  update;
    logic                  taken;
    logic [1:0]            way;
    logic [BRU_ADDR_W-1:0] pc;
    logic [BRU_ADDR_W-1:0] target;
  } bp_update_t;

  function automatic int flush_cnt_w(input int flush_cycles);
    return $clog2(flush_cycles + 1);
  endfunction

endpackage

// File: rtl/bru_sat_counter.sv
// ---------------------------------------------------------------------------
// bru_sat_counter
// Saturating event counter: adds one per cycle with inc high and sticks at
// all-ones.
//   clk   in  1      clock
//   rst   in  1      synchronous active-high reset, clears the count
//   inc   in  1      count this cycle
//   count out WIDTH  current count (registered)
// ---------------------------------------------------------------------------
module bru_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Execute-stage branch resolution. Compares each resolved branch/jump with
// the prediction carried from fetch, emits the predictor (BHT/BTB) update one
// cycle later and, on a mispredict, pulses a redirect and holds flush_o for
// FLUSH_CYCLES cycles. Exec inputs seen during the flush are wrong-path and
// ignored.
//
// Optional build macro: BRU_PERF_CNT_EN enables saturating resolve and
// mispredict counters; without it the counter ports are tied to zero.
//
// Ports
//   clk_i, arst_i (sync, active-high)
//   stall_exec_i, valid_exec_i, branch_instr_exec_i, jump_instr_exec_i,
//   branch_taken_exec_i, pred_taken_exec_i, way_exec_i[1:0],
//   pc_exec_i, target_exec_i, pred_target_exec_i  [ADDR_WIDTH-1:0]
//   bp_update_o, bp_taken_o, bp_way_o[1:0], bp_pc_o, bp_target_o
//   flush_o, redirect_valid_o, redirect_pc_o
//   branch_cnt_o, mispred_cnt_o  [CNT_WIDTH-1:0]
// ADDR_WIDTH must not exceed bru_pkg::BRU_ADDR_W.
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  stall_exec_i,
  input  logic                  valid_exec_i,
  input  logic                  branch_instr_exec_i,
  input  logic                  jump_instr_exec_i,
  input  logic                  branch_taken_exec_i,
  input  logic                  pred_taken_exec_i,
  input  logic [1:0]            way_exec_i,
  input  logic [ADDR_WIDTH-1:0] pc_exec_i,
  input  logic [ADDR_WIDTH-1:0] target_exec_i,
  input  logic [ADDR_WIDTH-1:0] pred_target_exec_i,
  output logic                  bp_update_o,
  output logic                  bp_taken_o,
  output logic [1:0]            bp_way_o,
  output logic [ADDR_WIDTH-1:0] bp_pc_o,
  output logic [ADDR_WIDTH-1:0] bp_target_o,
  output logic                  flush_o,
  output logic                  redirect_valid_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic [CNT_WIDTH-1:0]  branch_cnt_o,
  output logic [CNT_WIDTH-1:0]  mispred_cnt_o
);

  localparam int FCW = flush_cnt_w(FLUSH_CYCLES);

  bru_state_e            state;
  logic [FCW-1:0]        flush_cnt;

  logic                  evt_p0;
  logic                  taken_p0;
  logic                  mis_p0;
  logic [ADDR_WIDTH-1:0] next_pc_p0;

  bp_update_t            bp_p1;
  logic                  redirect_vld_p1;
  logic [ADDR_WIDTH-1:0] redirect_pc_p1;

  // ---- stage p0: resolve against the prediction (combinational) ----
  always_comb begin
    evt_p0     = valid_exec_i & ~stall_exec_i &
                 (branch_instr_exec_i | jump_instr_exec_i) & (state == IDLE);
    taken_p0   = jump_instr_exec_i | branch_taken_exec_i;
    // A taken/taken pair still mispredicts if the BTB supplied a stale target.
    mis_p0     = evt_p0 & ((taken_p0 != pred_taken_exec_i) |
                           (taken_p0 & pred_taken_exec_i &
                            (target_exec_i != pred_target_exec_i)));
    next_pc_p0 = taken_p0 ? target_exec_i : pc_exec_i + ADDR_WIDTH'(4);
  end

  // ---- stage p1: registered predictor update, redirect and flush FSM ----
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state           <= IDLE;
      flush_cnt       <= '0;
      redirect_vld_p1 <= 1'b0;
      redirect_pc_p1  <= '0;
      bp_p1           <= '0;
    end else begin
      bp_p1.update    <= evt_p0;
      if (evt_p0) begin
        bp_p1.taken  <= taken_p0;
        bp_p1.way    <= way_exec_i;
        bp_p1.pc     <= BRU_ADDR_W'(pc_exec_i);
        bp_p1.target <= BRU_ADDR_W'(target_exec_i);
      end

      redirect_vld_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (mis_p0) begin
            state           <= FLUSH;
            flush_cnt       <= FCW'(FLUSH_CYCLES - 1);
            redirect_vld_p1 <= 1'b1;
            redirect_pc_p1  <= next_pc_p0;
          end
        end
        FLUSH: begin
          // Counter holds the number of flush cycles still to follow this one.
          if (flush_cnt == '0) begin
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bp_update_o      = bp_p1.update;
  assign bp_taken_o       = bp_p1.taken;
  assign bp_way_o         = bp_p1.way;
  assign bp_pc_o          = bp_p1.pc[ADDR_WIDTH-1:0];
  assign bp_target_o      = bp_p1.target[ADDR_WIDTH-1:0];
  assign flush_o          = (state == FLUSH);
  assign redirect_valid_o = redirect_vld_p1;
  assign redirect_pc_o    = redirect_pc_p1;

`ifdef BRU_PERF_CNT_EN
  bru_sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (clk_i),
    .rst   (arst_i),
    .inc   (evt_p0),
    .count (branch_cnt_o)
  );

  bru_sat_counter #(.WIDTH(CNT_WIDTH)) u_mispred_cnt (
    .clk   (clk_i),
    .rst   (arst_i),
    .inc   (mis_p0),
    .count (mispred_cnt_o)
  );
`else
  assign branch_cnt_o  = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Self-checking bench for branch_resolve_unit (ADDR_WIDTH=64, FLUSH_CYCLES=2,
// CNT_WIDTH=4). Reference model tracks remaining flush cycles and the last
// predictor write as plain variables.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int AW = 64;
  localparam int FC = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic          valid, stall, br, j, bt, pt;
    logic [1:0]    way;
    logic [AW-1:0] pc, tgt, ptgt;
  } in_t;

  typedef struct {
    in_t           in;
    logic          e_upd, e_taken, e_rv, e_flush;
    logic [AW-1:0] e_rpc, e_target;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, valid, br, j, bt, pt;
  logic [1:0]    way;
  logic [AW-1:0] pc, tgt, ptgt;
  logic          bp_update, bp_taken, flush, redirect_valid;
  logic [1:0]    bp_way;
  logic [AW-1:0] bp_pc, bp_target, redirect_pc;
  logic [CW-1:0] branch_cnt, mispred_cnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  int            m_left;
  logic          m_upd, m_taken, m_rv;
  logic [1:0]    m_way;
  logic [AW-1:0] m_pc, m_target, m_rpc;
  int            m_bcnt, m_mcnt;

  branch_resolve_unit #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk_i               (clk),
    .arst_i              (rst),
    .stall_exec_i        (stall),
    .valid_exec_i        (valid),
    .branch_instr_exec_i (br),
    .jump_instr_exec_i   (j),
    .branch_taken_exec_i (bt),
    .pred_taken_exec_i   (pt),
    .way_exec_i          (way),
    .pc_exec_i           (pc),
    .target_exec_i       (tgt),
    .pred_target_exec_i  (ptgt),
    .bp_update_o         (bp_update),
    .bp_taken_o          (bp_taken),
    .bp_way_o            (bp_way),
    .bp_pc_o             (bp_pc),
    .bp_target_o         (bp_target),
    .flush_o             (flush),
    .redirect_valid_o    (redirect_valid),
    .redirect_pc_o       (redirect_pc),
    .branch_cnt_o        (branch_cnt),
    .mispred_cnt_o       (mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(input logic v, s, b, jj, t, p, input logic [1:0] w,
                             input logic [AW-1:0] a, tg, ptg);
    in_t r;
    r.valid = v; r.stall = s; r.br = b; r.j = jj; r.bt = t; r.pt = p;
    r.way = w; r.pc = a; r.tgt = tg; r.ptgt = ptg;
    return r;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_upd = 0; m_taken = 0; m_rv = 0; m_way = 0;
    m_pc = 0; m_target = 0; m_rpc = 0; m_bcnt = 0; m_mcnt = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step(input logic r, input in_t v);
    logic e, a, mis;
    if (r) begin
      model_reset();
      return;
    end
    e   = (m_left == 0) && v.valid && !v.stall && (v.br || v.j);
    a   = v.j || v.bt;
    mis = e && ((a != v.pt) || (a && v.tgt != v.ptgt));
    if (m_left > 0) m_left--;
    m_rv = 0;
    if (mis) begin
      m_left = FC;
      m_rv   = 1;
      m_rpc  = a ? v.tgt : v.pc + 64'd4;
    end
    m_upd = e;
    if (e) begin
      m_taken = a; m_way = v.way; m_pc = v.pc; m_target = v.tgt;
    end
`ifdef BRU_PERF_CNT_EN
    if (e && m_bcnt < CMAX) m_bcnt++;
    if (mis && m_mcnt < CMAX) m_mcnt++;
`endif
  endtask

  task automatic compare_model();
    chk("bp_update", AW'(bp_update), AW'(m_upd));
    chk("bp_taken", AW'(bp_taken), AW'(m_taken));
    chk("bp_way", AW'(bp_way), AW'(m_way));
    chk("bp_pc", bp_pc, m_pc);
    chk("bp_target", bp_target, m_target);
    chk("flush", AW'(flush), AW'(m_left > 0));
    chk("redirect_valid", AW'(redirect_valid), AW'(m_rv));
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("branch_cnt", AW'(branch_cnt), AW'(m_bcnt));
    chk("mispred_cnt", AW'(mispred_cnt), AW'(m_mcnt));
  endtask

  // Drive inputs, clock once, update model, compare 1 time unit after the edge.
  task automatic step(input logic r, input in_t v);
    rst = r; valid = v.valid; stall = v.stall; br = v.br; j = v.j;
    bt = v.bt; pt = v.pt; way = v.way; pc = v.pc; tgt = v.tgt; ptgt = v.ptgt;
    @(posedge clk);
    model_step(r, v);
    #1;
    compare_model();
  endtask

  in_t  idle_in, corr_in, dmis_in;
  vec_t vecs[9];
  int   seen_flush;

  initial begin
    idle_in = mk(0, 0, 0, 0, 0, 0, 2'd0, 64'h0, 64'h0, 64'h0);
    corr_in = mk(1, 0, 1, 0, 1, 1, 2'd1, 64'h100, 64'h200, 64'h200);
    dmis_in = mk(1, 0, 1, 0, 0, 1, 2'd2, 64'h100, 64'h200, 64'h200);

    //                 inputs                                                          upd tk rv fl rpc                      target
    vecs[0] = '{corr_in,                                                              1, 1, 0, 0, 64'h0,                   64'h200};
    vecs[1] = '{dmis_in,                                                              1, 0, 1, 1, 64'h104,                 64'h200};
    vecs[2] = '{mk(1, 0, 0, 1, 0, 1, 2'd3, 64'h100, 64'h400, 64'h300),               1, 1, 1, 1, 64'h400,                 64'h400};
    vecs[3] = '{mk(1, 0, 1, 0, 1, 0, 2'd0, 64'h80, 64'h40, 64'h0),                   1, 1, 1, 1, 64'h40,                  64'h40};
    vecs[4] = '{mk(1, 0, 1, 0, 0, 0, 2'd1, 64'h100, 64'h200, 64'h999),               1, 0, 0, 0, 64'h0,                   64'h200};
    vecs[5] = '{mk(1, 0, 0, 0, 1, 0, 2'd1, 64'h100, 64'h200, 64'h0),                 0, 0, 0, 0, 64'h0,                   64'h0};
    vecs[6] = '{mk(0, 0, 1, 0, 1, 0, 2'd1, 64'h100, 64'h200, 64'h0),                 0, 0, 0, 0, 64'h0,                   64'h0};
    vecs[7] = '{mk(1, 1, 1, 0, 1, 0, 2'd1, 64'h100, 64'h200, 64'h0),                 0, 0, 0, 0, 64'h0,                   64'h0};
    vecs[8] = '{mk(1, 0, 1, 0, 0, 1, 2'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'h10, 64'h10), 1, 0, 1, 1, 64'h2,                   64'h10};

    model_reset();
    step(1, idle_in);
    step(1, idle_in);
    chk("reset_flush", AW'(flush), '0);
    chk("reset_bp_update", AW'(bp_update), '0);
    chk("reset_redirect_pc", redirect_pc, '0);

    // Table-driven single-resolve vectors, each from a fresh reset.
    for (int i = 0; i < 9; i++) begin
      step(1, idle_in);
      step(0, vecs[i].in);
      chk($sformatf("vec%0d_upd", i), AW'(bp_update), AW'(vecs[i].e_upd));
      chk($sformatf("vec%0d_taken", i), AW'(bp_taken), AW'(vecs[i].e_taken));
      chk($sformatf("vec%0d_rv", i), AW'(redirect_valid), AW'(vecs[i].e_rv));
      chk($sformatf("vec%0d_flush", i), AW'(flush), AW'(vecs[i].e_flush));
      chk($sformatf("vec%0d_rpc", i), redirect_pc, vecs[i].e_rpc);
      chk($sformatf("vec%0d_target", i), bp_target, vecs[i].e_target);
      step(0, idle_in);
      step(0, idle_in);
    end

    // Flush length and wrong-path suppression: mispredicting resolves during FLUSH.
    step(1, idle_in);
    step(0, dmis_in);
    seen_flush = 0;
    if (flush) seen_flush++;
    step(0, mk(1, 0, 0, 1, 0, 0, 2'd3, 64'h500, 64'h900, 64'h0));
    chk("wp_no_update", AW'(bp_update), '0);
    chk("wp_no_redirect", AW'(redirect_valid), '0);
    chk("wp_rpc_stable", redirect_pc, 64'h104);
    if (flush) seen_flush++;
    step(0, mk(1, 0, 1, 0, 1, 0, 2'd3, 64'h600, 64'h900, 64'h0));
    chk("wp_no_update2", AW'(bp_update), '0);
    if (flush) seen_flush++;
    chk("flush_len", AW'(seen_flush), AW'(FC));
    chk("wp_bp_pc_hold", bp_pc, 64'h100);

    // Stall held 3 cycles, then released: exactly one update.
    step(1, idle_in);
    for (int i = 0; i < 3; i++) begin
      step(0, mk(1, 1, 1, 0, 1, 1, 2'd1, 64'h100, 64'h200, 64'h200));
      chk("stall_no_update", AW'(bp_update), '0);
    end
    step(0, corr_in);
    chk("stall_release_update", AW'(bp_update), 64'h1);
    step(0, idle_in);
    chk("stall_single_update", AW'(bp_update), '0);

    // Reset in the first FLUSH cycle.
    step(1, idle_in);
    step(0, dmis_in);
    chk("pre_reset_flush", AW'(flush), 64'h1);
    step(1, dmis_in);
    chk("midflush_reset_flush", AW'(flush), '0);
    chk("midflush_reset_rv", AW'(redirect_valid), '0);
    step(0, corr_in);
    chk("post_reset_idle_update", AW'(bp_update), 64'h1);
    chk("post_reset_no_flush", AW'(flush), '0);

    // Counter saturation (4-bit counters in this build).
    step(1, idle_in);
    for (int i = 0; i < 20; i++) step(0, corr_in);
    for (int i = 0; i < 20; i++) begin
      step(0, dmis_in);
      step(0, idle_in);
      step(0, idle_in);
    end
`ifdef BRU_PERF_CNT_EN
    chk("branch_cnt_sat", AW'(branch_cnt), AW'(CMAX));
    chk("mispred_cnt_sat", AW'(mispred_cnt), AW'(CMAX));
`else
    chk("branch_cnt_tied", AW'(branch_cnt), '0);
    chk("mispred_cnt_tied", AW'(mispred_cnt), '0);
`endif

    // Randomized traffic against the model.
    step(1, idle_in);
    for (int i = 0; i < 600; i++) begin
      in_t r;
      logic [AW-1:0] t;
      t = ($urandom_range(0, 1) != 0) ? 64'h2000 : {$urandom, $urandom};
      r = mk($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
             2'($urandom_range(0, 3)), {$urandom, $urandom}, t,
             ($urandom_range(0, 2) != 0) ? t : 64'h2000 + 64'h40);
      step($urandom_range(0, 59) == 0, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
